// File: rtl/agnus_dma_arbiter.sv
// agnus_dma_arbiter: fixed-priority chip-bus DMA arbiter with round-robin group, CPU-starvation throttle and data-phase grant tag
module agnus_dma_arbiter #(
    parameter int NCH = 8,
    parameter int AW = 20,
    parameter int RW = 8,
    parameter logic [NCH-1:0] RR_MASK = 8'h00,
    parameter logic [NCH-1:0] THROTTLE_MASK = 8'h40,
    parameter logic [NCH-1:0] WE_MASK = 8'h41,
    parameter int BLS_CNT_MAX = 3
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              clk7_en,
    input  logic              cck,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*AW-1:0] addr_in,
    input  logic [NCH*RW-1:0] reg_in,
    input  logic [NCH-1:0]    we_in,
    input  logic              cpu_req,
    input  logic [RW-1:0]     cpu_reg,
    input  logic              nasty,
    output logic [NCH-1:0]    gnt,
    output logic              dbr,
    output logic              cpu_custom,
    output logic [AW-1:0]     address_out,
    output logic [RW-1:0]     reg_address_out,
    output logic              dbwe,
    output logic [NCH-1:0]    dgnt,
    output logic              throttled
);
    localparam int CW = $clog2(BLS_CNT_MAX + 1);
    localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
    function automatic int lowest_bit(input logic [NCH-1:0] m);
        int r;
        r = NCH;
        for (int i = NCH - 1; i >= 0; i--) if (m[i]) r = i;
        return r;
    endfunction
    localparam int RR_LO = lowest_bit(RR_MASK);
    logic [CW-1:0]  bls_cnt;
    logic [PW-1:0]  rr_ptr, rr_w, rr_hi, rr_lo, np_idx, sel, rr_nxt;
    logic [NCH-1:0] ereq, nonrr, rrq;
    logic           np_hit, rr_hi_hit, rr_hit, rr_win, any;
    assign throttled = (bls_cnt == CW'(BLS_CNT_MAX)) & ~nasty;
    assign ereq = req & ~(throttled ? THROTTLE_MASK : '0);
    assign nonrr = ereq & ~RR_MASK;
    assign rrq = ereq & RR_MASK;
    always_comb begin
        np_hit = 1'b0;
        np_idx = '0;
        rr_hi_hit = 1'b0;
        rr_hi = '0;
        rr_hit = 1'b0;
        rr_lo = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (nonrr[i]) begin
                np_hit = 1'b1;
                np_idx = PW'(i);
            end
            if (rrq[i]) begin
                rr_hit = 1'b1;
                rr_lo = PW'(i);
            end
            if (rrq[i] && i >= int'(rr_ptr)) begin
                rr_hi_hit = 1'b1;
                rr_hi = PW'(i);
            end
        end
    end
    // The group competes at the priority of its lowest member, whether or not that member is requesting
    assign rr_w = rr_hi_hit ? rr_hi : rr_lo;
    assign rr_win = rr_hit && (!np_hit || RR_LO < int'(np_idx));
    assign sel = rr_win ? rr_w : np_idx;
    assign any = rr_win | np_hit;
    assign gnt = any ? NCH'(1) << sel : '0;
    assign dbr = any;
    assign cpu_custom = ~any;
    assign address_out = any ? addr_in[int'(sel)*AW +: AW] : '0;
    assign reg_address_out = any ? reg_in[int'(sel)*RW +: RW] : cpu_reg;
    assign dbwe = |(gnt & we_in & WE_MASK);
    assign rr_nxt = (int'(rr_w) == NCH - 1) ? '0 : rr_w + 1'b1;
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            bls_cnt <= '0;
            rr_ptr <= '0;
            dgnt <= '0;
        end else if (clk7_en) begin
            dgnt <= gnt;
            if (rr_win) rr_ptr <= rr_nxt;
            if (!cck) bls_cnt <= (nasty | ~cpu_req | ~dbr) ? '0 : (bls_cnt != CW'(BLS_CNT_MAX)) ? bls_cnt + 1'b1 : bls_cnt;
        end
    end
endmodule

// File: tb/tb_agnus_dma_arbiter.sv
// tb_agnus_dma_arbiter: directed vectors and multi-slot sequences for agnus_dma_arbiter (RR group = channels 4..7)
module tb_agnus_dma_arbiter;
    logic         clk = 1'b0, rst_n = 1'b0, clk7_en = 1'b0, cck = 1'b0, cpu_req = 1'b0, nasty = 1'b0;
    logic [7:0]   req = '0, we_in = '0, cpu_reg = 8'hFF;
    logic [159:0] addr_in;
    logic [63:0]  reg_in;
    logic [7:0]   gnt, dgnt, reg_address_out;
    logic         dbr, cpu_custom, dbwe, throttled;
    logic [19:0]  address_out;
    int n_chk = 0, n_fail = 0;

    agnus_dma_arbiter #(.RR_MASK(8'hF0)) dut (
        .clk(clk), ._reset(rst_n), .clk7_en(clk7_en), .cck(cck), .req(req),
        .addr_in(addr_in), .reg_in(reg_in), .we_in(we_in), .cpu_req(cpu_req),
        .cpu_reg(cpu_reg), .nasty(nasty), .gnt(gnt), .dbr(dbr), .cpu_custom(cpu_custom),
        .address_out(address_out), .reg_address_out(reg_address_out), .dbwe(dbwe),
        .dgnt(dgnt), .throttled(throttled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] we;
        logic [7:0] cpu_reg;
        int         exp_ch;
        logic       exp_we;
    } vec_t;

    function automatic logic [19:0] addr_of(input int i);
        return 20'hA0000 + 20'(i * 'h111);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vt[11];
    logic [7:0] exp_list[8];
    logic       thr_list[8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            addr_in[i*20 +: 20] = addr_of(i);
            reg_in[i*8 +: 8] = 8'h10 + 8'(i);
        end
        vt[0]  = '{8'h64, 8'h00, 8'hFF, 2, 1'b0};
        vt[1]  = '{8'h00, 8'h00, 8'hFF, -1, 1'b0};
        vt[2]  = '{8'h00, 8'hFF, 8'h5A, -1, 1'b0};
        vt[3]  = '{8'hFF, 8'hFF, 8'hFF, 0, 1'b1};
        vt[4]  = '{8'h02, 8'h02, 8'hFF, 1, 1'b0};
        vt[5]  = '{8'h01, 8'h01, 8'hFF, 0, 1'b1};
        vt[6]  = '{8'h18, 8'h00, 8'hFF, 3, 1'b0};
        vt[7]  = '{8'hF0, 8'h00, 8'hFF, 4, 1'b0};
        vt[8]  = '{8'hC0, 8'h40, 8'hFF, 6, 1'b1};
        vt[9]  = '{8'h80, 8'h80, 8'hFF, 7, 1'b0};
        vt[10] = '{8'h0C, 8'h00, 8'h33, 2, 1'b0};
        #2;
        chk("reset_dgnt", 32'(dgnt), 0);
        chk("reset_throttled", 32'(throttled), 0);
        rst_n = 1'b1;
        // Combinational vectors with clk7_en low so rr_ptr and the counter stay at reset values
        for (int k = 0; k < 11; k++) begin
            req = vt[k].req;
            we_in = vt[k].we;
            cpu_reg = vt[k].cpu_reg;
            #1;
            chk($sformatf("v%0d_gnt", k), 32'(gnt), vt[k].exp_ch < 0 ? 0 : 32'(1) << vt[k].exp_ch);
            chk($sformatf("v%0d_dbr", k), 32'(dbr), vt[k].exp_ch >= 0);
            chk($sformatf("v%0d_cpu", k), 32'(cpu_custom), vt[k].exp_ch < 0);
            chk($sformatf("v%0d_addr", k), 32'(address_out), vt[k].exp_ch < 0 ? 0 : 32'(addr_of(vt[k].exp_ch)));
            chk($sformatf("v%0d_reg", k), 32'(reg_address_out), vt[k].exp_ch < 0 ? 32'(vt[k].cpu_reg) : 32'(8'h10 + 8'(vt[k].exp_ch)));
            chk($sformatf("v%0d_dbwe", k), 32'(dbwe), 32'(vt[k].exp_we));
        end
        cpu_reg = 8'hFF;
        we_in = '0;
        // Data-phase tag: one-slot latency, held while clk7_en is low
        step();
        do_reset();
        req = 8'h64;
        clk7_en = 1'b1;
        step();
        chk("dgnt_after_slot", 32'(dgnt), 32'h04);
        clk7_en = 1'b0;
        req = 8'h01;
        step();
        chk("dgnt_hold", 32'(dgnt), 32'h04);
        clk7_en = 1'b1;
        step();
        chk("dgnt_next", 32'(dgnt), 32'h01);
        // Round robin between channels 6 and 7, pointer wraps 7 -> 0
        do_reset();
        req = 8'hC0;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk($sformatf("rr_slot%0d", s), 32'(gnt), (s % 2 == 0) ? 32'h40 : 32'h80);
            step();
        end
        // Starvation throttle of channel 6
        exp_list = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h00, 8'h40};
        thr_list = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        req = 8'h40;
        cpu_req = 1'b1;
        for (int s = 0; s < 8; s++) begin
            cck = s[0];
            #1;
            chk($sformatf("thr_gnt%0d", s), 32'(gnt), 32'(exp_list[s]));
            chk($sformatf("thr_flag%0d", s), 32'(throttled), 32'(thr_list[s]));
            if (thr_list[s]) chk($sformatf("thr_cpu%0d", s), 32'(cpu_custom), 1);
            step();
        end
        // Blitter-nasty disables throttling entirely
        do_reset();
        nasty = 1'b1;
        for (int s = 0; s < 8; s++) begin
            cck = s[0];
            #1;
            chk($sformatf("nasty_gnt%0d", s), 32'(gnt), 32'h40);
            chk($sformatf("nasty_thr%0d", s), 32'(throttled), 0);
            step();
        end
        nasty = 1'b0;
        // Build up counter, rr_ptr=5, dgnt, then reset between edges
        do_reset();
        cck = 1'b0;
        req = 8'h10;
        step();
        step();
        step();
        chk("pre_rst_thr", 32'(throttled), 1);
        chk("pre_rst_dgnt", 32'(dgnt), 32'h10);
        req = 8'h30;
        #1;
        chk("pre_rst_rrptr", 32'(gnt), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dgnt", 32'(dgnt), 0);
        chk("rst_thr", 32'(throttled), 0);
        chk("rst_gnt", 32'(gnt), 32'h10);
        rst_n = 1'b1;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
